opcode_sequencer: RTL and testbench
===================================

OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state and registered outputs.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 fetchOp  input  5  opcode field of the fetched word.
REQ-005 fetchValid  input  1  fetchOp holds a valid word.
REQ-006 fetchReady  output  1  combinational; the word is consumed on a cycle with fetchValid=1 and fetchReady=1.
REQ-007 stall  input  1  hazard hold request from hazard detection.
REQ-008 flush  input  1  taken-branch squash of the fetched word.
REQ-009 intReq  input  1  external interrupt request, level or pulse.
REQ-010 opCode  output  5  registered opcode presented to the control unit.
REQ-011 makeMeBubble  output  1  registered bubble request to the control unit.
REQ-012 intAck  output  1  registered one-cycle pulse when the interrupt sequence starts.
REQ-013 illegalOp  output  1  registered one-cycle pulse when a reserved opcode is fetched.

Function
REQ-014 States SHALL be ISSUE, CALL2, RET2, RTI2, INT2 and IMM.
REQ-015 Latency SHALL be one cycle: a decision in cycle N appears on opCode/makeMeBubble in cycle N+1.
REQ-016 Per-cycle priority SHALL be: rst > stall > pending second part > flush > interrupt > decode.
REQ-017 stall=1: state, opCode and intPending hold; makeMeBubble=1 next cycle; fetchReady=0.
REQ-018 ISSUE, fetchValid=0, no interrupt pending: emit 00000, makeMeBubble=0, fetchReady=1.
REQ-019 ISSUE, flush=1: fetchReady=1 (word discarded); emit 00000; state stays ISSUE.
REQ-020 ISSUE, intPending=1, no stall/flush: emit 11110; pulse intAck; fetchReady=0 (word kept for replay); clear intPending; go INT2.
REQ-021 INT2: emit 11111; fetchReady=0; return to ISSUE.
REQ-022 ISSUE, consumed 11000: emit 11000, go CALL2; CALL2 emits 11001, fetchReady=0, returns to ISSUE.
REQ-023 ISSUE, consumed 11010: emit 11010, go RET2; RET2 emits 11011, fetchReady=0, returns to ISSUE.
REQ-024 ISSUE, consumed 11100: emit 11100, go RTI2; RTI2 emits 11101, fetchReady=0, returns to ISSUE.
REQ-025 ISSUE, consumed 10001 (LDM): emit 10001, go IMM.
REQ-026 IMM: fetchReady=1; the next valid word is the immediate; emit 00000; return to ISSUE. With fetchValid=0, stay in IMM and emit 00000.
REQ-027 Fetched 11001, 11011, 11101, 11110 or 11111 SHALL be consumed, emitted as 00000, and pulse illegalOp.
REQ-028 All other consumed opcodes (00000-10000, 10010-10111) SHALL pass through unchanged with makeMeBubble=0.
REQ-029 CALL2/RET2/RTI2/INT2/IMM SHALL ignore flush and complete; only stall delays them.
REQ-030 intReq=1 in any cycle SHALL set sticky intPending.
REQ-031 An interrupt SHALL be taken only in ISSUE; requests during any other state wait until return to ISSUE.
REQ-032 A new intReq in the cycle intAck is issued SHALL re-set intPending.
REQ-033 intAck and illegalOp SHALL be single-cycle pulses, never asserted during stall.

Reset
REQ-034 With rst=1 at a clock edge: state=ISSUE, opCode=00000, makeMeBubble=0, intAck=0, illegalOp=0, intPending=0.
REQ-035 During rst, fetchReady SHALL be 0.
REQ-036 Reset asserted mid-sequence (e.g. in CALL2) SHALL abandon the second part; the first post-reset output is 00000.

Verification
REQ-037 Fetch 11000 then 01001 with fetchValid=1 -> opCode sequence 11000, 11001, 01001; fetchReady=0 during the CALL2 cycle.
REQ-038 intReq pulse while fetchOp=00100 in ISSUE -> 11110 with intAck=1, then 11111, then 00100 (replayed).
REQ-039 Fetch 10001 then immediate word 0x1F -> 10001, then 00000, with no illegalOp even though 0x1F is reserved as an opcode.
REQ-040 In RET2 with stall=1 for 2 cycles -> opCode holds 11010 with makeMeBubble=1 for 2 cycles, then 11011.
REQ-041 flush=1 during CALL2 -> 11001 still emitted; flush=1 in ISSUE with fetchOp=01010 -> 00000 emitted, word consumed.
REQ-042 rst asserted in INT2 -> next opCode=00000, intAck=0, state=ISSUE.

Source files
------------

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: expands multi-cycle opcodes, injects interrupt sequences and bubbles.
// One-cycle latency; fetchReady is combinational and held low on stall, reset and second parts.
module opcode_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] fetchOp,
  input  logic       fetchValid,
  output logic       fetchReady,
  input  logic       stall,
  input  logic       flush,
  input  logic       intReq,
  output logic [4:0] opCode,
  output logic       makeMeBubble,
  output logic       intAck,
  output logic       illegalOp
);

  typedef enum logic [2:0] {
    ST_ISSUE = 3'd0,
    ST_CALL2 = 3'd1,
    ST_RET2  = 3'd2,
    ST_RTI2  = 3'd3,
    ST_INT2  = 3'd4,
    ST_IMM   = 3'd5
  } state_t;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LDM   = 5'b10001;
  localparam logic [4:0] OP_CALL  = 5'b11000;
  localparam logic [4:0] OP_CALL2 = 5'b11001;
  localparam logic [4:0] OP_RET   = 5'b11010;
  localparam logic [4:0] OP_RET2  = 5'b11011;
  localparam logic [4:0] OP_RTI   = 5'b11100;
  localparam logic [4:0] OP_RTI2  = 5'b11101;
  localparam logic [4:0] OP_INT1  = 5'b11110;
  localparam logic [4:0] OP_INT2  = 5'b11111;

  state_t     state_q, state_d;
  logic [4:0] op_code_q, op_code_d;
  logic       bubble_q, bubble_d;
  logic       int_ack_q, int_ack_d;
  logic       illegal_q, illegal_d;
  logic       int_pending_q, int_pending_d;
  logic       fetch_ready;
  logic       int_now;

  // A request arriving this cycle is eligible immediately, so the fetched word is replayed.
  assign int_now = int_pending_q | intReq;

  always_comb begin
    state_d       = state_q;
    op_code_d     = OP_NOP;
    bubble_d      = 1'b0;
    int_ack_d     = 1'b0;
    illegal_d     = 1'b0;
    int_pending_d = int_now;
    fetch_ready   = 1'b0;

    if (stall) begin
      op_code_d = op_code_q;
      bubble_d  = 1'b1;
    end else begin
      case (state_q)
        ST_CALL2: begin
          op_code_d = OP_CALL2;
          state_d   = ST_ISSUE;
        end
        ST_RET2: begin
          op_code_d = OP_RET2;
          state_d   = ST_ISSUE;
        end
        ST_RTI2: begin
          op_code_d = OP_RTI2;
          state_d   = ST_ISSUE;
        end
        ST_INT2: begin
          op_code_d = OP_INT2;
          state_d   = ST_ISSUE;
        end
        ST_IMM: begin
          // The immediate word is swallowed, even if it looks like a reserved opcode.
          fetch_ready = 1'b1;
          if (fetchValid) begin
            state_d = ST_ISSUE;
          end
        end
        default: begin
          if (flush) begin
            fetch_ready = 1'b1;
          end else if (int_now) begin
            op_code_d     = OP_INT1;
            int_ack_d     = 1'b1;
            int_pending_d = 1'b0;
            state_d       = ST_INT2;
          end else begin
            fetch_ready = 1'b1;
            if (fetchValid) begin
              case (fetchOp)
                OP_CALL: begin
                  op_code_d = OP_CALL;
                  state_d   = ST_CALL2;
                end
                OP_RET: begin
                  op_code_d = OP_RET;
                  state_d   = ST_RET2;
                end
                OP_RTI: begin
                  op_code_d = OP_RTI;
                  state_d   = ST_RTI2;
                end
                OP_LDM: begin
                  op_code_d = OP_LDM;
                  state_d   = ST_IMM;
                end
                OP_CALL2, OP_RET2, OP_RTI2, OP_INT1, OP_INT2: begin
                  illegal_d = 1'b1;
                end
                default: begin
                  op_code_d = fetchOp;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ISSUE;
      op_code_q     <= OP_NOP;
      bubble_q      <= 1'b0;
      int_ack_q     <= 1'b0;
      illegal_q     <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_code_q     <= op_code_d;
      bubble_q      <= bubble_d;
      int_ack_q     <= int_ack_d;
      illegal_q     <= illegal_d;
      int_pending_q <= int_pending_d;
    end
  end

  assign fetchReady   = fetch_ready & ~rst;
  assign opCode       = op_code_q;
  assign makeMeBubble = bubble_q;
  assign intAck       = int_ack_q;
  assign illegalOp    = illegal_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Scoreboard bench for opcode_sequencer: directed scenarios followed by random traffic.
module tb_opcode_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] fetchOp;
  logic       fetchValid;
  logic       fetchReady;
  logic       stall;
  logic       flush;
  logic       intReq;
  logic [4:0] opCode;
  logic       makeMeBubble;
  logic       intAck;
  logic       illegalOp;

  opcode_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .fetchOp      (fetchOp),
    .fetchValid   (fetchValid),
    .fetchReady   (fetchReady),
    .stall        (stall),
    .flush        (flush),
    .intReq       (intReq),
    .opCode       (opCode),
    .makeMeBubble (makeMeBubble),
    .intAck       (intAck),
    .illegalOp    (illegalOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] op;
    logic       bub;
    logic       ack;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  logic rdy_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 0;

  // Reference model: pending follow-up opcode, immediate expected, sticky interrupt.
  int         m_follow   = -1;
  bit         m_want_imm = 0;
  bit         m_int      = 0;
  logic [4:0] m_last     = 5'd0;

  task automatic drive(input bit r, input bit fv, input logic [4:0] op,
                       input bit st, input bit fl, input bit ir);
    exp_t e;
    bit   rdy;
    bit   int_now;
    @(posedge clk);
    #1;
    rst = r; fetchValid = fv; fetchOp = op; stall = st; flush = fl; intReq = ir;
    e = '0;
    rdy = 0;
    int_now = m_int || ir;
    if (r) begin
      m_follow = -1; m_want_imm = 0; m_int = 0;
      e.op = 5'd0;
    end else if (st) begin
      e.op = m_last; e.bub = 1; m_int = int_now;
    end else if (m_follow >= 0) begin
      e.op = m_follow[4:0]; m_follow = -1; m_int = int_now;
    end else if (m_want_imm) begin
      rdy = 1; e.op = 5'd0; m_int = int_now;
      if (fv) m_want_imm = 0;
    end else if (fl) begin
      rdy = 1; e.op = 5'd0; m_int = int_now;
    end else if (int_now) begin
      e.op = 5'd30; e.ack = 1; m_follow = 31; m_int = 0;
    end else begin
      rdy = 1; m_int = 0;
      if (!fv) e.op = 5'd0;
      else if (op == 5'd24 || op == 5'd26 || op == 5'd28) begin
        e.op = op; m_follow = int'(op) + 1;
      end else if (op == 5'd17) begin
        e.op = op; m_want_imm = 1;
      end else if (op == 5'd25 || op == 5'd27 || op >= 5'd29) begin
        e.op = 5'd0; e.ill = 1;
      end else e.op = op;
    end
    m_last = e.op;
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 5'd0, 0, 0, 0);
  endtask

  // Monitor: fetchReady belongs to the current cycle, registered outputs to the previous one.
  initial begin
    exp_t e;
    logic r;
    forever begin
      @(negedge clk);
      if (done) break;
      if (rdy_q.size() > 0) begin
        r = rdy_q.pop_front();
        n_checks++;
        if (fetchReady !== r) begin
          n_fail++;
          $display("FAIL fetchReady t=%0t got=%b want=%b", $time, fetchReady, r);
        end
      end
      if (exp_q.size() > 1) begin
        e = exp_q.pop_front();
        n_checks++;
        if (opCode !== e.op || makeMeBubble !== e.bub || intAck !== e.ack || illegalOp !== e.ill) begin
          n_fail++;
          $display("FAIL outputs t=%0t got op=%b bub=%b ack=%b ill=%b want op=%b bub=%b ack=%b ill=%b",
                   $time, opCode, makeMeBubble, intAck, illegalOp, e.op, e.bub, e.ack, e.ill);
        end
      end
    end
  end

  initial begin
    rst = 1; fetchValid = 0; fetchOp = 0; stall = 0; flush = 0; intReq = 0;
    drive(1, 0, 5'd0, 0, 0, 0);
    drive(1, 1, 5'd18, 0, 0, 1);
    idle(1);
    // CALL expansion, next word held through the second part
    drive(0, 1, 5'd24, 0, 0, 0);
    drive(0, 1, 5'd9, 0, 0, 0);
    drive(0, 1, 5'd9, 0, 0, 0);
    idle(1);
    // interrupt with the fetched word replayed
    drive(0, 1, 5'd4, 0, 0, 1);
    drive(0, 1, 5'd4, 0, 0, 0);
    drive(0, 1, 5'd4, 0, 0, 0);
    idle(1);
    // LDM with a reserved-looking immediate, then a genuine reserved opcode
    drive(0, 1, 5'd17, 0, 0, 0);
    drive(0, 1, 5'd31, 0, 0, 0);
    drive(0, 1, 5'd27, 0, 0, 0);
    idle(1);
    // RET with a two-cycle stall in the second part
    drive(0, 1, 5'd26, 0, 0, 0);
    drive(0, 0, 5'd0, 1, 0, 0);
    drive(0, 0, 5'd0, 1, 0, 0);
    drive(0, 0, 5'd0, 0, 0, 0);
    idle(1);
    // flush ignored in CALL2, honoured in ISSUE
    drive(0, 1, 5'd24, 0, 0, 0);
    drive(0, 0, 5'd0, 0, 1, 0);
    drive(0, 1, 5'd10, 0, 1, 0);
    idle(1);
    // reset while in INT2
    drive(0, 0, 5'd0, 0, 0, 1);
    drive(1, 0, 5'd0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      automatic bit r  = ($urandom_range(0, 199) == 0);
      automatic bit fv = ($urandom_range(0, 3) != 0);
      automatic logic [4:0] op = 5'($urandom_range(0, 31));
      automatic bit st = ($urandom_range(0, 7) == 0);
      automatic bit fl = ($urandom_range(0, 9) == 0);
      automatic bit ir = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) op = 5'($urandom_range(24, 31));
      drive(r, fv, op, st, fl, ir);
    end
    idle(2);
    @(posedge clk);
    #2;
    done = 1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
